// File: rtl/canny_pkg.sv
// Shared definitions for the canny frame sink: FSM encoding, widths and the
// {last, data} word carried through the output FIFO.
package canny_pkg;
    localparam int PIX_W  = 8;
    localparam int DIM_W  = 11;
    localparam int LANES  = 4;
    localparam int WORD_W = PIX_W * LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } sink_state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } sink_word_t;
endpackage

// File: rtl/canny_sink_fifo.sv
// Synchronous word FIFO with a registered show-ahead output stage.
// Capacity (array plus output register) is DEPTH words.
module canny_sink_fifo
    import canny_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  sink_word_t wr_word,
    output logic       full,
    output logic       empty,
    output sink_word_t rd_word,
    output logic       rd_valid,
    input  logic       rd_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sink_word_t     mem [DEPTH];
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [CW-1:0]  mem_cnt_reg;
    sink_word_t     out_reg;
    logic           out_valid_reg;

    logic pop, out_free, wr_ok, mem_rd, mem_wr, bypass;

    always_comb begin
        pop      = out_valid_reg && rd_ready;
        out_free = !out_valid_reg || pop;
        full     = (mem_cnt_reg + CW'(out_valid_reg)) == CW'(DEPTH);
        empty    = !out_valid_reg && (mem_cnt_reg == '0);
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        wr_ok    = wr_en && (!full || pop);
        mem_rd   = out_free && (mem_cnt_reg != '0);
        bypass   = out_free && (mem_cnt_reg == '0) && wr_ok;
        mem_wr   = wr_ok && !bypass;
    end

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr_reg] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            mem_cnt_reg   <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (mem_wr)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (mem_rd) begin
                out_reg    <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end else if (bypass) begin
                out_reg <= wr_word;
            end
            if (out_free)
                out_valid_reg <= mem_rd || bypass;
            mem_cnt_reg <= mem_cnt_reg + CW'(mem_wr) - CW'(mem_rd);
        end
    end

    assign rd_word  = out_reg;
    assign rd_valid = out_valid_reg;
endmodule

// File: rtl/canny_frame_sink.sv
// Frame sink: counts one frame of pixels, packs four bytes per word and
// streams the words out through a FIFO with last-word and frame-done markers.
module canny_frame_sink
    import canny_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_LSB    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] IH,
    input  logic [11:0] IW,
    input  logic        pi_flag,
    input  logic [31:0] pi_data,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        frame_done,
    output logic        ovf_err
);
    sink_state_t       state_reg, state_next;
    logic [DIM_W-1:0]  w_reg, h_reg, x_reg, y_reg;
    logic [1:0]        lane_reg;
    logic [WORD_W-1:0] pack_reg;
    logic              push_reg;
    sink_word_t        push_word_reg;
    logic              ovf_reg;
    logic              done_reg;

    logic [PIX_W-1:0]  pix;
    logic [WORD_W-1:0] ins_word;
    logic              take, last_pix, word_done, drop;
    logic              fifo_full, fifo_empty;
    sink_word_t        fifo_word;
    logic              unused_ok;

    assign pix = pi_data[PIX_LSB +: PIX_W];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign ins_word[gi*PIX_W +: PIX_W] =
                (lane_reg == 2'(gi)) ? pix : pack_reg[gi*PIX_W +: PIX_W];
        end
    endgenerate

    always_comb begin
        take      = (state_reg == ST_RUN) && pi_flag;
        last_pix  = (x_reg == w_reg - DIM_W'(1)) && (y_reg == h_reg - DIM_W'(1));
        word_done = (lane_reg == 2'd3) || last_pix;
        drop      = push_reg && fifo_full && !(m_valid && m_ready);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start)
                    state_next = ((IW[DIM_W-1:0] == '0) || (IH[DIM_W-1:0] == '0))
                                 ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (take && last_pix) state_next = ST_FLUSH;
            // The last word may still sit in the push register for one cycle.
            ST_FLUSH: if (!push_reg && fifo_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            w_reg         <= '0;
            h_reg         <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            lane_reg      <= '0;
            pack_reg      <= '0;
            push_reg      <= 1'b0;
            push_word_reg <= '0;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_DONE);
            push_reg  <= take && word_done;
            if (take && word_done)
                push_word_reg <= '{last: last_pix, data: ins_word};
            if (drop)
                ovf_reg <= 1'b1;
            if ((state_reg == ST_IDLE) && start) begin
                w_reg    <= IW[DIM_W-1:0];
                h_reg    <= IH[DIM_W-1:0];
                x_reg    <= '0;
                y_reg    <= '0;
                lane_reg <= '0;
                pack_reg <= '0;
                ovf_reg  <= 1'b0;
            end
            if (take) begin
                lane_reg <= lane_reg + 2'd1;
                pack_reg <= word_done ? '0 : ins_word;
                if (x_reg == w_reg - DIM_W'(1)) begin
                    x_reg <= '0;
                    y_reg <= y_reg + DIM_W'(1);
                end else begin
                    x_reg <= x_reg + DIM_W'(1);
                end
            end
        end
    end

    canny_sink_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_reg),
        .wr_word  (push_word_reg),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_word  (fifo_word),
        .rd_valid (m_valid),
        .rd_ready (m_ready)
    );

    assign m_data     = fifo_word.data;
    assign m_last     = fifo_word.last;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = done_reg;
    assign ovf_err    = ovf_reg;

    // Bits of the input buses that carry no meaning for this block.
    assign unused_ok = &{1'b0, IH[11], IW[11], pi_data};
endmodule

// File: tb/tb_canny_frame_sink.sv
// Scoreboard bench for canny_frame_sink: stimulus pushes expected words,
// a monitor pops and compares every accepted word and watches the handshake.
module tb_canny_frame_sink;
    localparam int DEPTH = 4;

    logic        clk, rst, start, pi_flag, m_ready;
    logic [11:0] IH, IW;
    logic [31:0] pi_data, m_data;
    logic        m_valid, m_last, busy, frame_done, ovf_err;

    canny_frame_sink #(.FIFO_DEPTH(DEPTH), .PIX_LSB(8)) dut (
        .clk(clk), .rst(rst), .start(start), .IH(IH), .IW(IW),
        .pi_flag(pi_flag), .pi_data(pi_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0, bad = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  pix_q[$];
    int          done_cnt = 0, done_cyc = 0, acc_cnt = 0;
    bit          rand_ready = 0, ready_level = 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single driver of m_ready: fixed level or a random coin per cycle.
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Monitor: scoreboard compare, stall stability, frame_done pulse shape.
    logic [32:0] prev_word;
    bit          prev_stall = 0, prev_done = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_word});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {m_last, m_data}, 64'hDEAD_0000_0000_0000);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    $display("word %0d data=%08h last=%0b", acc_cnt, m_data, m_last);
                    check("word", {m_last, m_data}, e);
                end
                acc_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
            if (frame_done) begin
                check("done_busy_low", busy, 0);
                check("done_single", prev_done, 0);
                done_cnt++;
                done_cyc = cyc;
                $display("frame_done at cycle %0d", cyc);
            end
            prev_done = frame_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h, output int sc);
        tick();
        start = 1'b1;
        IW = {1'($urandom_range(0, 1)), 11'(w)};
        IH = {1'($urandom_range(0, 1)), 11'(h)};
        sc = cyc;
        tick();
        start = 1'b0;
    endtask

    // Reference: pixels taken four at a time in arrival order, lane0 first,
    // final word zero-padded and marked last; only the first 'keep' survive.
    task automatic push_expect(input int w, input int h, input int keep);
        int n, nw;
        n  = w * h;
        nw = (n + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            logic [31:0] word;
            word = 32'h0;
            for (int k = 0; k < 4; k++)
                if (wi * 4 + k < n)
                    word = word | (32'(pix_q[wi * 4 + k]) << (8 * k));
            if (wi < keep)
                exp_q.push_back({(wi == nw - 1) ? 1'b1 : 1'b0, word});
        end
    endtask

    task automatic send_pixels(input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    pi_flag = 1'b0;
                    pi_data = $urandom();
                    tick();
                end
            end
            begin
                logic [31:0] r;
                r = $urandom();
                pi_flag = 1'b1;
                pi_data = {r[31:16], pix_q[i], r[7:0]};
            end
            tick();
        end
        pi_flag = 1'b0;
    endtask

    task automatic fill_random(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom()));
    endtask

    task automatic wait_done(input string name, input int c0, input int budget);
        int n = 0;
        while (done_cnt == c0 && n < budget) begin
            tick();
            n++;
        end
        check(name, done_cnt - c0, 1);
        tick();
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic run_frame(input string name, input int w, input int h, input bit gaps);
        int sc, c0;
        c0 = done_cnt;
        push_expect(w, h, 1 << 30);
        do_start(w, h, sc);
        check({name, "_busy"}, busy, 1);
        send_pixels(w * h, gaps);
        wait_done(name, c0, 400);
        check({name, "_ovf"}, ovf_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sc, c0, a0;
        rst = 1'b0; start = 1'b0; pi_flag = 1'b0; pi_data = '0; IH = '0; IW = '0;
        m_ready = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {m_valid, m_last, busy, frame_done, ovf_err}, 0);
        check("reset_data", m_data, 0);
        rst = 1'b1;
        tick();

        // Two full words, sequential bytes.
        pix_q.delete();
        for (int i = 1; i <= 8; i++) pix_q.push_back(8'(i));
        run_frame("t1_4x2", 4, 2, 0);

        // Single padded word.
        pix_q.delete();
        pix_q.push_back(8'hAA); pix_q.push_back(8'hBB); pix_q.push_back(8'hCC);
        run_frame("t2_3x1", 3, 1, 0);

        // Overflow: downstream stalled for the whole frame.
        ready_level = 0;
        fill_random(64);
        c0 = done_cnt;
        a0 = acc_cnt;
        push_expect(8, 8, DEPTH);
        do_start(8, 8, sc);
        send_pixels(64, 0);
        repeat (4) tick();
        check("t3_ovf_set", ovf_err, 1);
        check("t3_valid_held", m_valid, 1);
        check("t3_none_accepted", acc_cnt - a0, 0);
        check("t3_still_busy", busy, 1);
        ready_level = 1;
        wait_done("t3_8x8", c0, 400);
        check("t3_word_count", acc_cnt - a0, DEPTH);

        // Zero width: no words, done two cycles after start, pixels ignored.
        fill_random(6);
        c0 = done_cnt;
        a0 = acc_cnt;
        do_start(0, 5, sc);
        check("t4_ovf_cleared", ovf_err, 0);
        send_pixels(6, 0);
        repeat (3) tick();
        check("t4_done_count", done_cnt - c0, 1);
        check("t4_done_latency", done_cyc - sc, 2);
        check("t4_no_words", acc_cnt - a0, 0);
        check("t4_idle", {m_valid, busy}, 0);

        // Reset mid-frame after 5 of 16 pixels.
        ready_level = 0;
        fill_random(16);
        do_start(4, 4, sc);
        send_pixels(5, 0);
        tick();
        check("t5_word_pending", m_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_ctrl", {m_valid, m_last, busy, frame_done, ovf_err}, 0);
        check("t5_rst_data", m_data, 0);
        tick();
        rst = 1'b1;
        ready_level = 1;
        tick();
        fill_random(16);
        run_frame("t5_4x4", 4, 4, 0);

        // Random back-pressure, odd frame size.
        rand_ready = 1;
        fill_random(15);
        run_frame("t6_5x3", 5, 3, 1);

        // Small random frames (at most four words, so never overflowing).
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 2);
            fill_random(w * h);
            run_frame("rand_frame", w, h, 1'($urandom_range(0, 1)));
        end
        rand_ready = 0;
        ready_level = 1;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
